// File: rtl/tl45_alu_mdu_if.sv
// Execute-stage bus for tl45_alu_mdu: decoded operands in; forwarding, writeback,
// branch and pipeline-control results out.
interface tl45_alu_mdu_if #(
    parameter int XLEN = 32,
    parameter int REGW = 4
);
    logic [4:0]      opcode;
    logic [REGW-1:0] dr;
    logic [3:0]      jmp_cond;
    logic [XLEN-1:0] sr1_val;
    logic [XLEN-1:0] sr2_val;
    logic [XLEN-1:0] target_offset;
    logic [XLEN-1:0] pc;
    logic            next_stall;   // stall from the downstream stage
    logic            next_flush;   // flush from the downstream stage
    logic            prev_stall;   // stall towards earlier stages
    logic            prev_flush;   // flush towards earlier stages
    logic [REGW-1:0] of_reg;
    logic [XLEN-1:0] of_val;
    logic [REGW-1:0] wb_dr;
    logic [XLEN-1:0] wb_value;
    logic            ld_newpc;
    logic [XLEN-1:0] br_pc;
    logic            busy;

    modport master (
        output opcode, dr, jmp_cond, sr1_val, sr2_val, target_offset, pc, next_stall, next_flush,
        input  prev_stall, prev_flush, of_reg, of_val, wb_dr, wb_value, ld_newpc, br_pc, busy
    );

    modport slave (
        input  opcode, dr, jmp_cond, sr1_val, sr2_val, target_offset, pc, next_stall, next_flush,
        output prev_stall, prev_flush, of_reg, of_val, wb_dr, wb_value, ld_newpc, br_pc, busy
    );
endinterface

// File: rtl/tl45_alu_mdu.sv
// TL45 execute stage: single-cycle ALU, flag-based branch resolver and, when
// TL45_MDU_EN is defined, an iterative radix-2 MUL/DIV/REM unit that stalls the pipe.
module tl45_alu_mdu #(
    parameter int XLEN = 32,
    parameter int REGW = 4
) (
    input logic           i_clk,
    input logic           i_reset,
    tl45_alu_mdu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [4:0] {
        OP_NOP  = 5'h00, OP_ADD = 5'h01, OP_SUB = 5'h02, OP_SHRA = 5'h05, OP_OR  = 5'h06,
        OP_XOR  = 5'h07, OP_AND = 5'h08, OP_NOT = 5'h09, OP_SHL  = 5'h0A, OP_SHR = 5'h0B,
        OP_BR   = 5'h0C, OP_CALL = 5'h0D, OP_RET = 5'h0E,
        OP_MUL  = 5'h10, OP_DIV = 5'h11, OP_REM = 5'h12
    } opcode_e;

    opcode_e         op;
    logic [3:0]      flags;          // {OF, ZF, CF, SF}
    logic [3:0]      alu_flags;
    logic [XLEN-1:0] alu_result, addend;
    logic [XLEN:0]   sum;
    logic [SHW-1:0]  sh;
    logic            writes, logic_op, cond_true, taken;
    logic [REGW-1:0] wb_dr;
    logic [XLEN-1:0] wb_value;
    logic            mdu_done, mdu_busy, mdu_stall, mdu_cf;
    logic [XLEN-1:0] mdu_result;
    logic [REGW-1:0] mdu_dr;
    logic            unused_pc;

    assign op        = opcode_e'(bus.opcode);
    assign sh        = bus.sr2_val[SHW-1:0];
    assign unused_pc = ^bus.pc;      // no current opcode consumes pc

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        addend     = (op == OP_SUB) ? ~bus.sr2_val : bus.sr2_val;
        sum        = {1'b0, bus.sr1_val} + {1'b0, addend} + {{XLEN{1'b0}}, op == OP_SUB};
        alu_result = '0;
        alu_flags  = flags;
        writes     = 1'b1;
        logic_op   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_result = sum[XLEN-1:0];
                alu_flags  = {(bus.sr1_val[XLEN-1] == addend[XLEN-1]) && (sum[XLEN-1] != bus.sr1_val[XLEN-1]),
                              sum[XLEN-1:0] == '0, sum[XLEN], sum[XLEN-1]};
            end
            OP_AND:  begin alu_result = bus.sr1_val & bus.sr2_val; logic_op = 1'b1; end
            OP_OR:   begin alu_result = bus.sr1_val | bus.sr2_val; logic_op = 1'b1; end
            OP_XOR:  begin alu_result = bus.sr1_val ^ bus.sr2_val; logic_op = 1'b1; end
            OP_NOT:  begin alu_result = ~bus.sr1_val;              logic_op = 1'b1; end
            OP_SHL:  alu_result = bus.sr1_val << sh;
            OP_SHR:  alu_result = bus.sr1_val >> sh;
            OP_SHRA: alu_result = $unsigned($signed(bus.sr1_val) >>> sh);
            OP_CALL: alu_result = bus.sr2_val - XLEN'(4);
            OP_RET:  alu_result = bus.sr2_val + XLEN'(4);
            default: writes = 1'b0;      // NOP, BR and (here) MDU opcodes
        endcase
        if (logic_op) alu_flags = {1'b0, alu_result == '0, 1'b0, alu_result[XLEN-1]};
    end

    always_comb begin
        case (bus.jmp_cond)
            4'd0:    cond_true = flags[3];
            4'd1:    cond_true = !flags[3];
            4'd2:    cond_true = flags[0];
            4'd3:    cond_true = !flags[0];
            4'd4:    cond_true = flags[2];
            4'd5:    cond_true = !flags[2];
            4'd6:    cond_true = flags[1];
            4'd7:    cond_true = !flags[1];
            4'd8:    cond_true = flags[1] | flags[2];
            4'd9:    cond_true = !(flags[1] | flags[2]);
            4'd10:   cond_true = flags[0] ^ flags[3];
            4'd11:   cond_true = !(flags[0] ^ flags[3]);
            4'd12:   cond_true = (flags[0] ^ flags[3]) | flags[2];
            4'd13:   cond_true = !((flags[0] ^ flags[3]) | flags[2]);
            default: cond_true = 1'b1;
        endcase
    end

    assign taken          = (op == OP_BR) && cond_true;
    assign bus.ld_newpc   = taken;
    assign bus.br_pc      = bus.sr1_val + bus.target_offset;
    assign bus.prev_flush = bus.next_flush | taken;
    assign bus.prev_stall = bus.next_stall | mdu_stall;
    assign bus.busy       = mdu_busy;
    assign bus.wb_dr      = wb_dr;
    assign bus.wb_value   = wb_value;

    always_comb begin
        bus.of_reg = '0;
        bus.of_val = '0;
        if (mdu_done) begin
            bus.of_reg = mdu_dr;
            bus.of_val = mdu_result;
        end else if (writes && !mdu_busy) begin
            bus.of_reg = bus.dr;
            bus.of_val = alu_result;
        end
    end

    // Flush wins over stall; a flush never touches the flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wb_dr    <= '0;
            wb_value <= '0;
            flags    <= '0;
        end else if (bus.next_flush) begin
            wb_dr    <= '0;
            wb_value <= '0;
        end else if (!bus.next_stall) begin
            if (mdu_done) begin
                wb_dr    <= mdu_dr;
                wb_value <= mdu_result;
                flags    <= {1'b0, mdu_result == '0, mdu_cf, mdu_result[XLEN-1]};
            end else if (writes && !mdu_busy) begin
                wb_dr    <= bus.dr;
                wb_value <= alu_result;
                flags    <= alu_flags;
            end else begin
                wb_dr    <= '0;
                wb_value <= '0;
            end
        end
    end

`ifdef TL45_MDU_EN
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} mdu_state_e;

    mdu_state_e      state, state_nx;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] r_acc, r_x, r_y, s_acc, s_x, s_y;
    logic [XLEN:0]   diff;
    opcode_e         m_op;
    logic [REGW-1:0] m_dr;
    logic            is_mdu, accept;

    assign is_mdu = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    assign accept = (state == MDU_IDLE) && is_mdu && !bus.next_stall && !bus.next_flush;

    always_comb begin
        state_nx = state;
        case (state)
            MDU_IDLE: if (accept) state_nx = MDU_BUSY;
            MDU_BUSY: if (count == CW'(2)) state_nx = MDU_DONE;
            MDU_DONE: state_nx = MDU_IDLE;
            default:  state_nx = MDU_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || bus.next_flush) state <= MDU_IDLE;
        else if (!bus.next_stall)      state <= state_nx;
    end

    // MUL: acc += x when y[0], x <<= 1, y >>= 1. DIV/REM: restoring step, acc is the
    // partial remainder, y shifts the dividend out and the quotient in.
    always_comb begin
        diff  = {r_acc, r_y[XLEN-1]} - {1'b0, r_x};
        s_acc = r_acc;
        s_x   = r_x;
        s_y   = r_y;
        if (m_op == OP_MUL) begin
            s_acc = r_acc + (r_y[0] ? r_x : '0);
            s_x   = r_x << 1;
            s_y   = r_y >> 1;
        end else begin
            s_acc = diff[XLEN] ? {r_acc[XLEN-2:0], r_y[XLEN-1]} : diff[XLEN-1:0];
            s_y   = {r_y[XLEN-2:0], ~diff[XLEN]};
        end
    end

    // BUSY performs XLEN-1 registered steps; the last step is taken combinationally in DONE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count <= '0;
            r_acc <= '0;
            r_x   <= '0;
            r_y   <= '0;
            m_op  <= OP_NOP;
            m_dr  <= '0;
        end else if (!bus.next_flush && !bus.next_stall) begin
            if (accept) begin
                count <= CW'(XLEN);
                r_acc <= '0;
                r_x   <= (op == OP_MUL) ? bus.sr1_val : bus.sr2_val;
                r_y   <= (op == OP_MUL) ? bus.sr2_val : bus.sr1_val;
                m_op  <= op;
                m_dr  <= bus.dr;
            end else if (state == MDU_BUSY) begin
                count <= count - CW'(1);
                r_acc <= s_acc;
                r_x   <= s_x;
                r_y   <= s_y;
            end
        end
    end

    assign mdu_done   = (state == MDU_DONE);
    assign mdu_busy   = (state != MDU_IDLE);
    assign mdu_stall  = mdu_busy || (is_mdu && !bus.next_flush);
    assign mdu_result = (m_op == OP_DIV) ? s_y : s_acc;
    assign mdu_cf     = (m_op != OP_MUL) && (r_x == '0);
    assign mdu_dr     = m_dr;
`else
    assign mdu_done   = 1'b0;
    assign mdu_busy   = 1'b0;
    assign mdu_stall  = 1'b0;
    assign mdu_result = '0;
    assign mdu_cf     = 1'b0;
    assign mdu_dr     = '0;
`endif
endmodule

// File: tb/tb_tl45_alu_mdu.sv
// Directed self-checking bench for tl45_alu_mdu; MDU vectors apply when TL45_MDU_EN is defined.
module tb_tl45_alu_mdu;
    localparam int XLEN = 32;
    localparam int REGW = 4;
    localparam logic [4:0] OP_NOP = 5'h00, OP_ADD = 5'h01, OP_SUB = 5'h02, OP_SHRA = 5'h05,
                           OP_OR = 5'h06, OP_XOR = 5'h07, OP_AND = 5'h08, OP_NOT = 5'h09,
                           OP_SHL = 5'h0A, OP_SHR = 5'h0B, OP_BR = 5'h0C, OP_CALL = 5'h0D,
                           OP_RET = 5'h0E, OP_MUL = 5'h10, OP_DIV = 5'h11, OP_REM = 5'h12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   stall_hi;

    always #5 clk = ~clk;

    tl45_alu_mdu_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

    tl45_alu_mdu #(.XLEN(XLEN), .REGW(REGW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [REGW-1:0] dr,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bus.opcode  = op;
        bus.dr      = dr;
        bus.sr1_val = a;
        bus.sr2_val = b;
    endtask

    // Observes a flag through a BR with the given condition, between clock edges.
    task automatic probe_cond(input string tag, input logic [3:0] cond, input logic exp);
        bus.opcode   = OP_BR;
        bus.jmp_cond = cond;
        #1;
        check(tag, bus.ld_newpc, exp);
        bus.opcode   = OP_NOP;
        bus.jmp_cond = 4'd0;
    endtask

    task automatic probe_flags(input string tag, input logic [3:0] exp);  // {OF,ZF,CF,SF}
        probe_cond({tag, ".of"}, 4'd0, exp[3]);
        probe_cond({tag, ".zf"}, 4'd4, exp[2]);
        probe_cond({tag, ".cf"}, 4'd6, exp[1]);
        probe_cond({tag, ".sf"}, 4'd2, exp[0]);
        #1;
    endtask

    task automatic alu_vec(input string tag, input logic [4:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] res, input logic [3:0] fl);
        drive(op, 4'd4, a, b);
        #1;
        check({tag, ".fwd"}, bus.of_val, res);
        tick();
        check({tag, ".dr"}, bus.wb_dr, 4'd4);
        check({tag, ".value"}, bus.wb_value, res);
        probe_flags(tag, fl);
    endtask

`ifdef TL45_MDU_EN
    task automatic mdu_vec(input string tag, input logic [4:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] res, input logic [3:0] fl);
        drive(op, 4'd2, a, b);
        repeat (XLEN + 1) tick();
        drive(OP_NOP, 4'd0, '0, '0);
        check({tag, ".dr"}, bus.wb_dr, 4'd2);
        check({tag, ".value"}, bus.wb_value, res);
        probe_flags(tag, fl);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode = OP_NOP; bus.dr = '0; bus.jmp_cond = '0; bus.sr1_val = '0; bus.sr2_val = '0;
        bus.target_offset = '0; bus.pc = '0; bus.next_stall = 1'b0; bus.next_flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset.dr", bus.wb_dr, 0);
        check("reset.value", bus.wb_value, 0);
        check("reset.busy", bus.busy, 0);
        check("reset.stall", bus.prev_stall, 0);
        probe_flags("reset", 4'b0000);

        // Signed overflow on ADD.
        drive(OP_ADD, 4'd3, 32'h7FFF_FFFF, 32'h1);
        #1;
        check("add.fwd_reg", bus.of_reg, 3);
        check("add.fwd_val", bus.of_val, 32'h8000_0000);
        tick();
        check("add.dr", bus.wb_dr, 3);
        check("add.value", bus.wb_value, 32'h8000_0000);
        probe_flags("add", 4'b1001);
        probe_cond("add.jl", 4'd10, 1'b0);
        probe_cond("add.jg", 4'd13, 1'b1);
        probe_cond("add.jmp", 4'd15, 1'b1);

        // SUB 5-5 then a taken je.
        drive(OP_SUB, 4'd1, 32'd5, 32'd5);
        tick();
        check("sub.dr", bus.wb_dr, 1);
        check("sub.value", bus.wb_value, 0);
        probe_flags("sub", 4'b0110);
        drive(OP_BR, 4'd9, 32'h100, 32'h0);
        bus.target_offset = 32'h20;
        bus.jmp_cond = 4'd4;
        #1;
        check("br.ld_newpc", bus.ld_newpc, 1);
        check("br.flush", bus.prev_flush, 1);
        check("br.pc", bus.br_pc, 32'h120);
        check("br.fwd_reg", bus.of_reg, 0);
        tick();
        check("br.dr", bus.wb_dr, 0);
        check("br.value", bus.wb_value, 0);
        probe_cond("br.jne", 4'd5, 1'b0);
        probe_cond("br.jbe", 4'd8, 1'b1);
        probe_cond("br.ja", 4'd9, 1'b0);

        alu_vec("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);
        alu_vec("and", OP_AND, 32'hF0F0, 32'h0FF0, 32'h00F0, 4'b0000);
        alu_vec("or", OP_OR, 32'hF000_0000, 32'h1, 32'hF000_0001, 4'b0001);
        alu_vec("xor", OP_XOR, 32'h1234, 32'h1234, 32'h0, 4'b0100);
        alu_vec("shra", OP_SHRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 4'b0100);
        alu_vec("shr", OP_SHR, 32'h8000_0000, 32'h4, 32'h0800_0000, 4'b0100);
        alu_vec("shl", OP_SHL, 32'h1, 32'd31, 32'h8000_0000, 4'b0100);
        alu_vec("not", OP_NOT, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'b0001);
        alu_vec("call", OP_CALL, 32'h0, 32'h100, 32'hFC, 4'b0001);
        alu_vec("ret", OP_RET, 32'h0, 32'h100, 32'h104, 4'b0001);

        // Downstream stall holds the registers, forwarding stays live.
        drive(OP_ADD, 4'd7, 32'd1, 32'd2);
        bus.next_stall = 1'b1;
        #1;
        check("stall.up", bus.prev_stall, 1);
        check("stall.fwd", bus.of_val, 3);
        tick();
        check("stall.hold_dr", bus.wb_dr, 4);
        check("stall.hold_value", bus.wb_value, 32'h104);
        bus.next_stall = 1'b0;
        tick();
        check("stall.release_dr", bus.wb_dr, 7);
        check("stall.release_value", bus.wb_value, 3);

        // Flush beats stall and leaves flags alone.
        drive(OP_ADD, 4'd7, 32'hFFFF_FFFF, 32'h1);
        bus.next_stall = 1'b1;
        bus.next_flush = 1'b1;
        #1;
        check("flush.up", bus.prev_flush, 1);
        tick();
        bus.next_stall = 1'b0;
        bus.next_flush = 1'b0;
        drive(OP_NOP, 4'd7, '0, '0);
        check("flush.dr", bus.wb_dr, 0);
        check("flush.value", bus.wb_value, 0);
        probe_flags("flush", 4'b0000);

        drive(OP_NOP, 4'd7, 32'd1, 32'd2);
        #1;
        check("nop.fwd_reg", bus.of_reg, 0);
        tick();
        check("nop.dr", bus.wb_dr, 0);

        drive(OP_SUB, 4'd1, 32'd5, 32'd5);
        tick();
`ifdef TL45_MDU_EN
        // MUL 6x7: stall for XLEN+1 cycles, forward in DONE, write back after it.
        drive(OP_MUL, 4'd5, 32'd6, 32'd7);
        stall_hi = 0;
        for (int c = 0; c < XLEN + 4; c++) begin
            if (c == XLEN + 1) drive(OP_NOP, 4'd0, '0, '0);
            #1;
            if (bus.prev_stall) stall_hi++;
            if (c == 1) begin
                check("mul.busy", bus.busy, 1);
                check("mul.busy_fwd", bus.of_reg, 0);
            end
            if (c == XLEN) begin
                check("mul.done_fwd_reg", bus.of_reg, 5);
                check("mul.done_fwd_val", bus.of_val, 42);
            end
            if (c == XLEN + 1) begin
                check("mul.dr", bus.wb_dr, 5);
                check("mul.value", bus.wb_value, 42);
            end
            tick();
        end
        check("mul.stall_cycles", stall_hi, XLEN + 1);
        probe_flags("mul", 4'b0000);

        mdu_vec("div0", OP_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 4'b0011);
        mdu_vec("rem7", OP_REM, 32'd100, 32'd7, 32'd2, 4'b0000);
        mdu_vec("div7", OP_DIV, 32'd100, 32'd7, 32'd14, 4'b0000);
        mdu_vec("rem0", OP_REM, 32'd100, 32'd0, 32'd100, 4'b0010);
        mdu_vec("mul_big", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 4'b0000);
        mdu_vec("mul_wrap", OP_MUL, 32'h1_0000, 32'h1_0000, 32'h0, 4'b0100);
        mdu_vec("div_msb", OP_DIV, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 4'b0000);

        // Flush in cycle 10 aborts a DIV without touching flags.
        drive(OP_SUB, 4'd1, 32'd5, 32'd5);
        tick();
        drive(OP_DIV, 4'd6, 32'd100, 32'd7);
        repeat (10) tick();
        check("abort.busy_before", bus.busy, 1);
        bus.next_flush = 1'b1;
        tick();
        bus.next_flush = 1'b0;
        drive(OP_NOP, 4'd0, '0, '0);
        #1;
        check("abort.busy", bus.busy, 0);
        check("abort.stall", bus.prev_stall, 0);
        check("abort.dr", bus.wb_dr, 0);
        check("abort.value", bus.wb_value, 0);
        probe_flags("abort", 4'b0110);
        repeat (XLEN) tick();
        check("abort.no_late_wb", bus.wb_dr, 0);

        // Reset in cycle 5 aborts a DIV and clears flags.
        drive(OP_DIV, 4'd6, 32'd100, 32'd7);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(OP_NOP, 4'd0, '0, '0);
        #1;
        check("rst_mid.busy", bus.busy, 0);
        check("rst_mid.stall", bus.prev_stall, 0);
        check("rst_mid.dr", bus.wb_dr, 0);
        check("rst_mid.value", bus.wb_value, 0);
        probe_flags("rst_mid", 4'b0000);
`else
        // Without the MDU, MUL decodes as NOP.
        drive(OP_MUL, 4'd5, 32'd6, 32'd7);
        #1;
        check("nomdu.fwd_reg", bus.of_reg, 0);
        stall_hi = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.prev_stall) stall_hi++;
            tick();
        end
        check("nomdu.stall_cycles", stall_hi, 0);
        check("nomdu.busy", bus.busy, 0);
        check("nomdu.dr", bus.wb_dr, 0);
        check("nomdu.value", bus.wb_value, 0);
        probe_flags("nomdu", 4'b0110);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(OP_NOP, 4'd0, '0, '0);
        probe_flags("nomdu_rst", 4'b0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tl45_alu_mdu.md
# tl45_alu_mdu

Parametrised execute stage for the TL45 pipeline. It combines the single-cycle ALU and branch resolver with an iterative multiply/divide unit (MDU). MUL, DIV and REM run for XLEN+1 cycles and stall earlier stages while they do. The block sits between decode/operand-fetch and writeback, and provides operand forwarding, flag-based branch resolution and flush propagation.

## Interface
- XLEN, 32: datapath width. Must be a power of two and at least 8.
- REGW, 4: register index width.
- i_clk  in  1  clock
- i_reset  in  1  reset. Synchronous, active-high.
- i_pipe_stall  in  1  downstream stall. The whole stage holds.
- i_pipe_flush  in  1  downstream flush.
- o_pipe_stall  out  1  stall to earlier stages: i_pipe_stall OR mdu_busy.
- o_pipe_flush  out  1  flush to earlier stages: i_pipe_flush OR taken branch.
- i_opcode  in  5  opcode. ADD 01, SUB 02, SHRA 05, OR 06, XOR 07, AND 08, NOT 09, SHL 0A, SHR 0B, BR 0C, CALL 0D, RET 0E, MUL 10, DIV 11, REM 12. All others are NOP.
- i_dr  in  REGW  destination register.
- i_jmp_cond  in  4  branch condition code.
- i_sr1_val, i_sr2_val, i_target_offset, i_pc  in  XLEN  operands.
- o_of_reg  out  REGW  forwarded register index. 0 means none.
- o_of_val  out  XLEN  forwarded value.
- o_dr  out  REGW  registered destination for the next stage.
- o_value  out  XLEN  registered result.
- o_ld_newpc  out  1  branch taken.
- o_br_pc  out  XLEN  i_sr1_val + i_target_offset, mod 2^XLEN.
- o_busy  out  1  MDU is in a state other than IDLE.

## Operation
- Single-cycle ops
  - ADD/SUB: full-width add. SUB computes a + ~b + 1. CF is the carry-out. OF = (a_msb == b'_msb) && (r_msb != a_msb), where b' is the effective addend.
  - SHL/SHR/SHRA: shift amount is i_sr2_val[log2(XLEN)-1:0]. SHRA is arithmetic.
  - CALL: i_sr2_val - 4. RET: i_sr2_val + 4.
- Flags register {OF,ZF,CF,SF}
  - ADD and SUB update all four flags.
  - AND/OR/XOR/NOT update ZF and SF, and clear OF and CF.
  - MUL/DIV/REM update ZF and SF from the result and clear OF. CF = 1 on divide-by-zero, otherwise 0.
  - All other ops leave the flags unchanged.
- Branch conditions, codes 0-13 in order: jo, jno, js, jns, je, jne, jc, jnc, jbe (CF|ZF), ja, jl (SF^OF), jge, jle, jg. Codes 14-15 are unconditional.
- A taken branch asserts o_ld_newpc and o_pipe_flush combinationally in the same cycle.
- BR and NOP register o_dr=0 and o_value=0.
- MDU FSM has states IDLE, BUSY and DONE.
  - IDLE→BUSY: a MUL/DIV/REM is present, with no stall and no flush. The block latches unsigned operands, op and dr, and loads count = XLEN.
  - BUSY: one radix-2 step per cycle. MUL is shift-add. DIV/REM is restoring division. count decrements; at 1 the FSM goes to DONE.
  - DONE: the result drives o_of_reg/o_of_val combinationally. At the edge, o_dr/o_value/flags are written and the FSM returns to IDLE.
- Divide-by-zero: quotient is all-ones, remainder is the dividend.
- MUL returns the low XLEN bits of the product.
- Operand forwarding: o_of_reg/o_of_val are 0 for NOP, BR, and MDU opcodes in IDLE/BUSY. Otherwise they carry i_dr and the combinational result.

## Timing
- Reset: o_dr=0, o_value=0, flags=0, FSM in IDLE, o_busy=0.
- Single-cycle latency: inputs in cycle N appear on o_dr/o_value after the edge ending cycle N.
- MDU latency
  - The op is accepted in cycle 0, is BUSY for cycles 1..XLEN-1, and is DONE in cycle XLEN.
  - o_pipe_stall is high for cycles 0..XLEN, which is XLEN+1 cycles.
  - The result is registered at the end of cycle XLEN. The next instruction is consumed in cycle XLEN+1.
  - During stall cycles the stage registers o_dr=0 and o_value=0 (bubbles).
- i_pipe_stall: every register, including the FSM and count, holds. Forwarding outputs stay combinational.
- Flush: any state goes to IDLE next cycle, o_dr=0 and o_value=0. Flags are not changed by a flush.
- Flush beats stall when both are asserted in the same cycle.
- Reset mid-operation: the MDU aborts, nothing is written back, and flags are cleared.
- Taken branch: o_pipe_flush is asserted, and the stage itself registers o_dr=0 and o_value=0.

## Configuration
- TL45_MDU_EN
  - Defined: MUL/DIV/REM and the FSM are built.
  - Undefined: opcodes 10-12 decode as NOP, o_busy ties to 0, o_pipe_stall = i_pipe_stall, and no MDU logic is synthesised.

## Test plan
- ADD 0x7FFFFFFF+1 with dr=3: after one edge o_dr=3, o_value=0x80000000, flags OF=1, ZF=0, CF=0, SF=1.
- SUB 5-5, then BR je with sr1=0x100, offset=0x20: o_ld_newpc=1, o_br_pc=0x120 and o_pipe_flush=1 in the same cycle. Next cycle o_dr=0.
- MUL 6×7 with dr=5: o_pipe_stall is high for exactly 33 cycles. o_of_val=42 in cycle 32. After the edge o_dr=5 and o_value=42.
- DIV 100/0 with dr=2: o_value=0xFFFFFFFF and CF=1. Then REM 100/7 gives o_value=2 and CF=0.
- DIV in flight with i_pipe_flush in cycle 10: next cycle o_busy=0, o_pipe_stall=0, o_dr=0, flags unchanged. With i_reset in cycle 5 instead: all outputs 0 and flags 0.
- Build without TL45_MDU_EN, MUL 6×7: o_pipe_stall never rises, o_dr=0, o_value=0.
